// File: rtl/frog_game_controller_pkg.sv
// Shared game parameters for the frog game: state encoding, default
// parameter values and a helper that sizes the frame counter.
package frog_game_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DYING     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_t;

   localparam int DEF_START_LIVES  = 3;
   localparam int DEF_MAX_LEVEL    = 9;
   localparam int DEF_DEATH_FRAMES = 60;
   localparam int DEF_WIN_FRAMES   = 30;

   localparam logic [7:0] SCORE_MAX = 8'hFF;

   // Frame counter must hold the larger of the two sequence lengths without
   // wrapping, and is never narrower than 7 bits.
   function automatic int frame_cnt_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m + 1);
      return (w < 7) ? 7 : w;
   endfunction

endpackage

// File: rtl/frog_game_controller_frame_timer.sv
// Frame timer: counts frame ticks while enabled, clears on request,
// saturates instead of wrapping, and flags the tick that reaches the limit.
module frame_timer
   import frog_game_controller_pkg::*;
#(
   parameter int WIDTH     = 7,
   parameter int BLINK_BIT = 3
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_tick,
   input  logic [WIDTH-1:0] i_limit,
   output logic             o_blink_next,
   output logic             o_done
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_next;

   // Next count: clear has priority, otherwise a saturating increment per tick.
   always_comb begin
      w_count_next = r_count;
      if (i_clear) begin
         w_count_next = '0;
      end else if (i_tick && (r_count != CNT_MAX)) begin
         w_count_next = r_count + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   // Done marks the tick that brings the count to the limit; the blink bit is
   // taken from the value the counter will hold after this edge so the
   // registered sprite-blink output lines up with the counter.
   assign o_done       = i_tick && !i_clear && (w_count_next == i_limit);
   assign o_blink_next = w_count_next[BLINK_BIT];

endmodule

// File: rtl/frog_game_controller.sv
// Frog game controller: sequences title, play, death and level-up phases,
// and keeps level, lives and score for the rest of the game logic.
module frog_game_controller
   import frog_game_controller_pkg::*;
#(
   parameter int START_LIVES  = DEF_START_LIVES,
   parameter int MAX_LEVEL    = DEF_MAX_LEVEL,
   parameter int DEATH_FRAMES = DEF_DEATH_FRAMES,
   parameter int WIN_FRAMES   = DEF_WIN_FRAMES
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start_btn,
   input  logic       i_frame_tick,
   input  logic       i_death_collision,
   input  logic       i_win_collision,
   output logic [3:0] o_current_level,
   output logic [1:0] o_lives,
   output logic [7:0] o_score,
   output logic       o_frog_respawn,
   output logic       o_freeze,
   output logic       o_game_over,
   output logic       o_death_flash
);

   localparam int               CNT_W      = frame_cnt_width(DEATH_FRAMES, WIN_FRAMES);
   localparam logic [CNT_W-1:0] DEATH_LIM  = CNT_W'(DEATH_FRAMES);
   localparam logic [CNT_W-1:0] WIN_LIM    = CNT_W'(WIN_FRAMES);
   localparam logic [3:0]       LEVEL_MAX  = 4'(MAX_LEVEL);
   localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

   game_state_t r_state;
   game_state_t w_state_next;
   logic [3:0]  r_level;
   logic [3:0]  w_level_next;
   logic [1:0]  r_lives;
   logic [1:0]  w_lives_next;
   logic [7:0]  r_score;
   logic [7:0]  w_score_next;
   logic        r_respawn;
   logic        w_respawn_next;
   logic        r_freeze;
   logic        w_freeze_next;
   logic        r_game_over;
   logic        w_game_over_next;
   logic        r_death_flash;
   logic        w_death_flash_next;

   logic             w_timer_clear;
   logic [CNT_W-1:0] w_timer_limit;
   logic             w_timer_done;
   logic             w_blink_next;

   // The counter only runs inside the two timed phases; everywhere else it is
   // held at zero, so each timed phase starts from a cleared count.
   assign w_timer_clear = !((r_state == ST_DYING) || (r_state == ST_LEVEL_UP));
   assign w_timer_limit = (r_state == ST_DYING) ? DEATH_LIM : WIN_LIM;

   frame_timer #(
      .WIDTH     (CNT_W),
      .BLINK_BIT (3)
   ) u_frame_timer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_timer_clear),
      .i_tick       (i_frame_tick),
      .i_limit      (w_timer_limit),
      .o_blink_next (w_blink_next),
      .o_done       (w_timer_done)
   );

   // State and output registers; every output is a flop.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= ST_IDLE;
         r_level       <= 4'd0;
         r_lives       <= LIVES_INIT;
         r_score       <= 8'd0;
         r_respawn     <= 1'b0;
         r_freeze      <= 1'b1;
         r_game_over   <= 1'b0;
         r_death_flash <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_level       <= w_level_next;
         r_lives       <= w_lives_next;
         r_score       <= w_score_next;
         r_respawn     <= w_respawn_next;
         r_freeze      <= w_freeze_next;
         r_game_over   <= w_game_over_next;
         r_death_flash <= w_death_flash_next;
      end
   end

   // Next-state and next-output logic; collisions only matter on frame ticks in PLAY.
   always_comb begin
      w_state_next   = r_state;
      w_level_next   = r_level;
      w_lives_next   = r_lives;
      w_score_next   = r_score;
      w_respawn_next = 1'b0;

      case (r_state)
         ST_IDLE, ST_GAME_OVER: begin
            if (i_start_btn) begin
               w_state_next   = ST_PLAY;
               w_level_next   = 4'd1;
               w_lives_next   = LIVES_INIT;
               w_score_next   = 8'd0;
               w_respawn_next = 1'b1;
            end
         end
         ST_PLAY: begin
            if (i_frame_tick) begin
               // Death wins over a simultaneous win.
               if (i_death_collision) begin
                  w_state_next = ST_DYING;
                  if (r_lives != 2'd0) begin
                     w_lives_next = r_lives - 2'd1;
                  end
               end else if (i_win_collision) begin
                  w_state_next = ST_LEVEL_UP;
                  w_level_next = (r_level >= LEVEL_MAX) ? LEVEL_MAX : r_level + 4'd1;
                  w_score_next = (r_score == SCORE_MAX) ? SCORE_MAX : r_score + 8'd1;
               end
            end
         end
         ST_DYING: begin
            if (w_timer_done) begin
               if (r_lives == 2'd0) begin
                  w_state_next = ST_GAME_OVER;
               end else begin
                  w_state_next   = ST_PLAY;
                  w_respawn_next = 1'b1;
               end
            end
         end
         ST_LEVEL_UP: begin
            if (w_timer_done) begin
               w_state_next   = ST_PLAY;
               w_respawn_next = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      w_freeze_next      = (w_state_next != ST_PLAY);
      w_game_over_next   = (w_state_next == ST_GAME_OVER);
      w_death_flash_next = (w_state_next == ST_DYING) && w_blink_next;
   end

   assign o_current_level = r_level;
   assign o_lives         = r_lives;
   assign o_score         = r_score;
   assign o_frog_respawn  = r_respawn;
   assign o_freeze        = r_freeze;
   assign o_game_over     = r_game_over;
   assign o_death_flash   = r_death_flash;

endmodule

// File: tb/tb_frog_game_controller.sv
// Directed bench for the frog game controller with a queue-based scoreboard.
module tb_frog_game_controller;

   logic clk         = 1'b0;
   logic reset       = 1'b1;
   logic start_btn   = 1'b0;
   logic frame_tick  = 1'b0;
   logic death_coll  = 1'b0;
   logic win_coll    = 1'b0;

   logic [3:0] level;
   logic [1:0] lives;
   logic [7:0] score;
   logic       respawn;
   logic       freeze;
   logic       game_over;
   logic       flash;

   always #5 clk = ~clk;

   frog_game_controller #(
      .START_LIVES  (3),
      .MAX_LEVEL    (9),
      .DEATH_FRAMES (60),
      .WIN_FRAMES   (30)
   ) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_start_btn       (start_btn),
      .i_frame_tick      (frame_tick),
      .i_death_collision (death_coll),
      .i_win_collision   (win_coll),
      .o_current_level   (level),
      .o_lives           (lives),
      .o_score           (score),
      .o_frog_respawn    (respawn),
      .o_freeze          (freeze),
      .o_game_over       (game_over),
      .o_death_flash     (flash)
   );

   typedef struct {
      int          when;
      bit          async_chk;
      logic [17:0] vec;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Hand-maintained expected outputs, updated by the directed sequence.
   logic [3:0] e_level = 4'd0;
   logic [1:0] e_lives = 2'd3;
   logic [7:0] e_score = 8'd0;
   logic       e_resp  = 1'b0;
   logic       e_frz   = 1'b1;
   logic       e_go    = 1'b0;
   logic       e_fl    = 1'b0;

   wire [17:0] act_vec = {level, lives, score, respawn, freeze, game_over, flash};

   function automatic logic [17:0] exp_vec();
      return {e_level, e_lives, e_score, e_resp, e_frz, e_go, e_fl};
   endfunction

   function automatic string fmt(input logic [17:0] v);
      return $sformatf("lvl=%0d lives=%0d score=%0d resp=%0b frz=%0b go=%0b flash=%0b",
                       v[17:14], v[13:12], v[11:4], v[3], v[2], v[1], v[0]);
   endfunction

   task automatic compare(input exp_t e);
      string nm;
      nm = (e.name == "") ? "cycle" : e.name;
      n_checks++;
      if (act_vec === e.vec) begin
         n_pass++;
         if (e.name != "") $display("ok   cyc %0d %s: %s", cyc, nm, fmt(act_vec));
      end else begin
         $display("FAIL cyc %0d %s: got %s, want %s", cyc, nm, fmt(act_vec), fmt(e.vec));
      end
   endtask

   // Synchronous monitor: one sample per clock, just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (q.size() > 0 && !q[0].async_chk && q[0].when <= cyc) begin
            e = q.pop_front();
            compare(e);
         end
      end
   end

   // Asynchronous-reset monitor: samples just after reset rises.
   initial begin
      exp_t ea;
      forever begin
         @(posedge reset);
         #1;
         if (q.size() > 0 && q[0].async_chk) begin
            ea = q.pop_front();
            compare(ea);
         end
      end
   end

   task automatic set_e(input logic [3:0] lv, input logic [1:0] li, input logic [7:0] sc,
                        input logic rs, input logic fz, input logic go, input logic fl);
      e_level = lv; e_lives = li; e_score = sc;
      e_resp = rs; e_frz = fz; e_go = go; e_fl = fl;
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic step(input bit st, input bit tk, input bit dc, input bit wc, input string nm);
      @(negedge clk);
      start_btn  = st;
      frame_tick = tk;
      death_coll = dc;
      win_coll   = wc;
      q.push_back('{when: cyc + 1, async_chk: 1'b0, vec: exp_vec(), name: nm});
   endtask

   task automatic death_seq(input bit both, input string nm);
      e_lives = e_lives - 2'd1;
      e_frz = 1'b1; e_resp = 1'b0; e_fl = 1'b0;
      step(1'b0, 1'b1, 1'b1, both, nm);
      for (int k = 1; k <= 60; k++) begin
         if (k < 60) begin
            e_fl = ((k & 8) != 0);
         end else if (e_lives == 2'd0) begin
            e_go = 1'b1; e_frz = 1'b1; e_fl = 1'b0;
         end else begin
            e_resp = 1'b1; e_frz = 1'b0; e_fl = 1'b0;
         end
         step(k == 5, 1'b1, k == 7, k == 9, (k == 60) ? {nm, "_done"} : "");
         if (k == 30) step(1'b0, 1'b0, 1'b0, 1'b0, "");
      end
      if (e_lives != 2'd0) begin
         e_resp = 1'b0;
         step(1'b0, 1'b0, 1'b0, 1'b0, "");
      end
   endtask

   task automatic win_seq(input string nm);
      e_level = (e_level >= 4'd9) ? 4'd9 : e_level + 4'd1;
      e_score = (e_score == 8'd255) ? 8'd255 : e_score + 8'd1;
      e_frz = 1'b1; e_resp = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b1, nm);
      for (int k = 1; k <= 30; k++) begin
         if (k == 30) begin
            e_resp = 1'b1; e_frz = 1'b0;
         end
         step(k == 12, 1'b1, k == 10, k == 11, (k == 30 && nm != "") ? {nm, "_done"} : "");
      end
      e_resp = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, "");
   endtask

   initial begin
      // Reset state while reset is held.
      set_e(4'd0, 2'd3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, "reset_hold");
      @(negedge clk);
      reset = 1'b0;
      start_btn = 1'b0; frame_tick = 1'b0; death_coll = 1'b0; win_coll = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

      // First start after reset.
      set_e(4'd1, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, "start");
      e_resp = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, "respawn_one_cycle");

      // Collisions without a frame tick are ignored.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b1, (i == 4), (i == 9) ? "death_no_tick" : "");
      end

      death_seq(1'b0, "death1");
      win_seq("win_l2");
      death_seq(1'b1, "death_and_win");
      death_seq(1'b0, "death3");
      step(1'b0, 1'b1, 1'b1, 1'b1, "gameover_hold");

      // Restart from GAME_OVER.
      set_e(4'd1, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, "restart");
      e_resp = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, "");

      // Climb to the top level, then keep winning until the score saturates.
      for (int w = 0; w < 8; w++) win_seq((w == 7) ? "reach_l9" : "");
      win_seq("win_at_max");
      while (e_score != 8'd255) win_seq("");
      win_seq("score_sat");

      // Reset in the middle of a death sequence.
      e_lives = 2'd2; e_frz = 1'b1; e_fl = 1'b0;
      step(1'b0, 1'b1, 1'b1, 1'b0, "death_for_reset");
      for (int k = 1; k <= 20; k++) begin
         e_fl = ((k & 8) != 0);
         step(1'b0, 1'b1, 1'b0, 1'b0, (k == 20) ? "dying_tick20" : "");
      end
      @(negedge clk);
      set_e(4'd0, 2'd3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      q.push_back('{when: 0, async_chk: 1'b1, vec: exp_vec(), name: "async_reset"});
      frame_tick = 1'b0;
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0, "reset_hold2");
      @(negedge clk);
      reset = 1'b0;
      start_btn = 1'b0; frame_tick = 1'b0;
      set_e(4'd1, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, "start_after_reset");
      e_resp = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, "");

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, want sequence completion");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
